fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the register file.
- Owns the program counter and drives the instruction-memory request/ready handshake.
- Captures fetched words into the IF/ID pipeline register.
- Supplies the current PC to the register file's PCin port, for R15 reads.
- Honours hazard stalls and taken-branch redirects from the control unit.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'hE1A0_0000, word placed in IF/ID when invalid or flushed (mov r0,r0)

Ports:
CLK  in  1  clock; all state updates on rising edge
RST  in  1  synchronous, active-high reset
STALL  in  1  hazard stall from control unit; freezes PC and IF/ID
BR_TAKEN  in  1  taken branch in a later stage; redirect PC and flush IF/ID
BR_TARGET  in  32  branch target address
IMEM_REQ  out  1  instruction fetch request
IMEM_ADDR  out  32  fetch address; always equals PC
IMEM_RDY  in  1  memory returns IMEM_DATA this cycle
IMEM_DATA  in  32  fetched instruction word
IF_ID_INSTR  out  32  registered instruction to decode
IF_ID_PC  out  32  registered fetch address + 4
IF_ID_VALID  out  1  IF/ID holds a real instruction
PC_RF  out  32  current PC, to register file PCin

Behaviour:
- Reset (RST=1 at edge), regardless of state:
  - PC=RESET_PC; state=IDLE; skid buffer cleared.
  - IF_ID_INSTR=NOP_INSTR; IF_ID_PC=0; IF_ID_VALID=0.
  - IMEM_REQ=0 while in IDLE. IMEM_ADDR and PC_RF equal PC at all times.
- States:
  - IDLE: REQ=0. Next cycle -> FETCH. One dead cycle after reset.
  - FETCH: REQ=1, ADDR=PC.
    - RDY=1 and STALL=0: IF/ID <= {IMEM_DATA, PC+4, VALID=1}; PC <= PC+4; stay FETCH. Sustains 1 instruction/cycle.
    - RDY=1 and STALL=1: word goes into the skid buffer; IF/ID and PC unchanged; -> HOLD.
    - RDY=0: stay FETCH. REQ and ADDR must remain stable until RDY; STALL has no effect here.
  - HOLD: REQ=0; IF/ID and PC frozen.
    - When STALL=0: IF/ID <= {skid, PC+4, VALID=1}; PC <= PC+4; -> FETCH.
  - DRAIN: redirect pending while a request is outstanding. REQ=1, ADDR=old PC.
    - When RDY=1: data discarded; PC <= saved target; -> FETCH.
- Branch (priority: RST > BR_TAKEN > STALL):
  - Target is BR_TARGET with bits [1:0] forced to 00.
  - Every branch sets IF_ID_VALID=0 and IF_ID_INSTR=NOP_INSTR at that edge.
  - In FETCH with RDY=1, in HOLD, or in IDLE: PC <= target; skid discarded; -> FETCH.
  - In FETCH with RDY=0: target saved; -> DRAIN.
  - In DRAIN: a further BR_TAKEN overwrites the saved target.
- STALL with no branch: IF/ID holds its value, including VALID.
- Arithmetic: PC+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0); IF_ID_PC wraps the same way.
- Latency: a word accepted at edge N is visible on IF_ID_* after edge N.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds outputs FETCH_CNT [31:0] and STALL_CNT [31:0].
  - FETCH_CNT increments on each IF/ID load with VALID=1.
  - STALL_CNT increments each cycle STALL=1 in FETCH or HOLD.
  - Both clear on RST and saturate at 32'hFFFF_FFFF.
- Undefined: the ports and logic are absent; core behaviour is identical.

Test Plan:
- Reset then RDY tied 1:
  - IDLE cycle has REQ=0.
  - Then ADDR=0,4,8 on consecutive cycles.
  - IF_ID_PC=4,8,12 with VALID=1 one cycle after each fetch.
- RDY=0 for 3 cycles at PC=0x10: REQ=1 and ADDR=0x10 stable; IF/ID unchanged; PC advances to 0x14 only after RDY.
- STALL=1 with RDY=1 at PC=0x20, data 0xDEADBEEF:
  - HOLD, REQ=0, IF/ID frozen for 2 cycles.
  - On STALL=0, IF_ID_INSTR=0xDEADBEEF, IF_ID_PC=0x24; next ADDR=0x24.
- BR_TAKEN, BR_TARGET=0x103, while RDY=1: next ADDR=0x100; IF_ID_VALID=0, IF_ID_INSTR=NOP_INSTR.
- BR_TAKEN while RDY=0 at PC=0x40, target 0x200:
  - ADDR stays 0x40 until RDY; returned data discarded.
  - Next ADDR=0x200.
- RESET_PC=32'hFFFF_FFFC: first fetch at 0xFFFF_FFFC gives IF_ID_PC=0; next ADDR=0. With FETCH_PERF_CNT_EN, FETCH_CNT=1.

Source files
------------

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage that feeds the register file and decode. It owns the
// program counter and runs the instruction-memory request/ready handshake. It
// captures each fetched word into the IF/ID pipeline register. It also supplies
// the current PC to the register file for R15 reads.
//
// The control unit drives two inputs into this stage:
//   - hazard stalls, which freeze the PC and IF/ID;
//   - taken-branch redirects, which retarget the PC and flush IF/ID.
//
// A one-entry skid buffer keeps a word that arrives during a stall. Without it
// that word would be lost, because the request is dropped while stalled.
//
// If a branch arrives while a fetch is still outstanding, the redirect is
// parked in DRAIN. The stage waits for that fetch to return, throws the data
// away, and only then moves to the target. This keeps REQ and ADDR stable
// until RDY.
//
// Optional build macro: FETCH_PERF_CNT_EN
//   When defined, the FETCH_CNT and STALL_CNT performance counters are added.
//   Both saturate at all-ones.
//
// Ports:
//   CLK          in   1   clock; all state updates on rising edge
//   RST          in   1   synchronous active-high reset
//   STALL        in   1   hazard stall; freezes PC and IF/ID
//   BR_TAKEN     in   1   taken branch; redirect PC, flush IF/ID
//   BR_TARGET    in  32   branch target (bits [1:0] ignored)
//   IMEM_REQ     out  1   instruction fetch request
//   IMEM_ADDR    out 32   fetch address (always the PC)
//   IMEM_RDY     in   1   IMEM_DATA valid this cycle
//   IMEM_DATA    in  32   fetched instruction word
//   IF_ID_INSTR  out 32   registered instruction to decode
//   IF_ID_PC     out 32   registered fetch address + 4
//   IF_ID_VALID  out  1   IF/ID holds a real instruction
//   PC_RF        out 32   current PC, to register file PCin
//   FETCH_CNT    out 32   (FETCH_PERF_CNT_EN) valid IF/ID loads
//   STALL_CNT    out 32   (FETCH_PERF_CNT_EN) stalled cycles in FETCH/HOLD
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'hE1A0_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        STALL,
  input  logic        BR_TAKEN,
  input  logic [31:0] BR_TARGET,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_RDY,
  input  logic [31:0] IMEM_DATA,
  output logic [31:0] IF_ID_INSTR,
  output logic [31:0] IF_ID_PC,
  output logic        IF_ID_VALID,
  output logic [31:0] PC_RF
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] FETCH_CNT,
  output logic [31:0] STALL_CNT
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] skid_q, skid_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ifpc_q, ifpc_d;
  logic        valid_q, valid_d;
  logic        req;
  logic        if_load;
  logic [31:0] br_tgt;
  logic [31:0] pc_plus4;

  // Branch targets are always word aligned.
  assign br_tgt   = {BR_TARGET[31:2], 2'b00};
  // Natural 32-bit wrap: 32'hFFFF_FFFC + 4 = 0.
  assign pc_plus4 = pc_q + 32'd4;

  // NOTE: every signal gets a default at the top of this block, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    skid_d  = skid_q;
    tgt_d   = tgt_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    valid_d = valid_q;
    req     = 1'b0;
    if_load = 1'b0;

    // Any taken branch kills whatever is sitting in IF/ID, whatever the state.
    if (BR_TAKEN) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (BR_TAKEN) pc_d = br_tgt;
      end

      FETCH: begin
        req = 1'b1;
        if (BR_TAKEN) begin
          if (IMEM_RDY) begin
            pc_d = br_tgt;
          end else begin
            // Request in flight: park the target and wait for it to return.
            tgt_d   = br_tgt;
            state_d = DRAIN;
          end
        end else if (IMEM_RDY) begin
          if (STALL) begin
            skid_d  = IMEM_DATA;
            state_d = HOLD;
          end else begin
            if_load = 1'b1;
            instr_d = IMEM_DATA;
          end
        end
      end

      HOLD: begin
        if (BR_TAKEN) begin
          pc_d    = br_tgt;
          skid_d  = '0;
          state_d = FETCH;
        end else if (!STALL) begin
          if_load = 1'b1;
          instr_d = skid_q;
          state_d = FETCH;
        end
      end

      DRAIN: begin
        req = 1'b1;
        if (BR_TAKEN) tgt_d = br_tgt;
        if (IMEM_RDY) begin
          // The returning word belongs to the old path and is dropped. A
          // branch arriving in the same cycle is the newest and wins.
          pc_d    = BR_TAKEN ? br_tgt : tgt_q;
          state_d = FETCH;
        end
      end

      default: state_d = IDLE;
    endcase

    if (if_load) begin
      ifpc_d  = pc_plus4;
      valid_d = 1'b1;
      pc_d    = pc_plus4;
    end
  end

  // NOTE: state registers use non-blocking assignments so that every flop
  // samples pre-edge values, whatever order the statements are written in.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      // NOTE: the skid data is cleared on reset even though it is only read in
      // HOLD, so that it never powers up as X.
      skid_q  <= '0;
      tgt_q   <= '0;
      instr_q <= NOP_INSTR;
      ifpc_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      skid_q  <= skid_d;
      tgt_q   <= tgt_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      valid_q <= valid_d;
    end
  end

  assign IMEM_REQ    = req;
  assign IMEM_ADDR   = pc_q;
  assign PC_RF       = pc_q;
  assign IF_ID_INSTR = instr_q;
  assign IF_ID_PC    = ifpc_q;
  assign IF_ID_VALID = valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;
  logic        stall_seen;

  assign stall_seen = STALL && (state_q == FETCH || state_q == HOLD);

  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (if_load && fetch_cnt_q != 32'hFFFF_FFFF) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (stall_seen && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign FETCH_CNT = fetch_cnt_q;
  assign STALL_CNT = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed bench for fetch_stage. There are two instances:
//   - u_dut uses RESET_PC = 0 and runs the sequential, wait-state, stall,
//     branch and drain scenarios.
//   - u_wrap uses RESET_PC = 32'hFFFF_FFFC and shows the PC+4 wrap to zero.
//
// Instruction memory answers combinationally with {16'hC0DE, ADDR[15:0]}
// unless an override word is selected.
//
// Timing: inputs change on the falling edge, and outputs are checked on that
// same falling edge, before the new inputs are driven.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'hE1A0_0000;

  logic        CLK = 1'b0;
  logic        RST;
  logic        STALL;
  logic        BR_TAKEN;
  logic [31:0] BR_TARGET;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_RDY;
  logic [31:0] IMEM_DATA;
  logic [31:0] IF_ID_INSTR;
  logic [31:0] IF_ID_PC;
  logic        IF_ID_VALID;
  logic [31:0] PC_RF;

  logic        use_ovr;
  logic [31:0] ovr_data;

  // Wrap-test instance signals.
  logic        rst2;
  logic        w_stall = 1'b0;
  logic        w_br = 1'b0;
  logic [31:0] w_tgt = 32'h0;
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_rdy = 1'b1;
  logic [31:0] w_data = 32'h1111_2222;
  logic [31:0] w_instr;
  logic [31:0] w_ifpc;
  logic        w_valid;
  logic [31:0] w_pcrf;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt, stall_cnt, w_fetch_cnt, w_stall_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  assign IMEM_DATA = use_ovr ? ovr_data : {16'hC0DE, IMEM_ADDR[15:0]};

  fetch_stage #(.RESET_PC(32'h0000_0000)) u_dut (
    .CLK(CLK), .RST(RST), .STALL(STALL), .BR_TAKEN(BR_TAKEN), .BR_TARGET(BR_TARGET),
    .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_RDY(IMEM_RDY), .IMEM_DATA(IMEM_DATA),
    .IF_ID_INSTR(IF_ID_INSTR), .IF_ID_PC(IF_ID_PC), .IF_ID_VALID(IF_ID_VALID), .PC_RF(PC_RF)
`ifdef FETCH_PERF_CNT_EN
    , .FETCH_CNT(fetch_cnt), .STALL_CNT(stall_cnt)
`endif
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .CLK(CLK), .RST(rst2), .STALL(w_stall), .BR_TAKEN(w_br), .BR_TARGET(w_tgt),
    .IMEM_REQ(w_req), .IMEM_ADDR(w_addr), .IMEM_RDY(w_rdy), .IMEM_DATA(w_data),
    .IF_ID_INSTR(w_instr), .IF_ID_PC(w_ifpc), .IF_ID_VALID(w_valid), .PC_RF(w_pcrf)
`ifdef FETCH_PERF_CNT_EN
    , .FETCH_CNT(w_fetch_cnt), .STALL_CNT(w_stall_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  initial begin
    RST = 1'b1; STALL = 1'b0; BR_TAKEN = 1'b0; BR_TARGET = '0;
    IMEM_RDY = 1'b1; use_ovr = 1'b0; ovr_data = '0; rst2 = 1'b1;
    repeat (2) @(posedge CLK);
    step();

    // Reset state; the stage is in IDLE with REQ low.
    check("rst_req",   32'(IMEM_REQ), 0);
    check("rst_addr",  IMEM_ADDR, 0);
    check("rst_pcrf",  PC_RF, 0);
    check("rst_valid", 32'(IF_ID_VALID), 0);
    check("rst_instr", IF_ID_INSTR, NOP);
    check("rst_ifpc",  IF_ID_PC, 0);
    RST = 1'b0;

    step();  // IDLE -> FETCH
    check("fetch_req",  32'(IMEM_REQ), 1);
    check("fetch_addr", IMEM_ADDR, 0);

    // Back-to-back fetches at 0, 4, 8, 0xC.
    for (int i = 1; i <= 4; i++) begin
      step();
      check("seq_addr",  IMEM_ADDR, 32'(i * 4));
      check("seq_ifpc",  IF_ID_PC, 32'(i * 4));
      check("seq_valid", 32'(IF_ID_VALID), 1);
      check("seq_instr", IF_ID_INSTR, {16'hC0DE, 16'(i * 4 - 4)});
    end

    // Three wait states at 0x10. STALL is pulsed once and must not matter.
    IMEM_RDY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      STALL = (i == 1);
      step();
      check("ws_req",   32'(IMEM_REQ), 1);
      check("ws_addr",  IMEM_ADDR, 32'h10);
      check("ws_ifpc",  IF_ID_PC, 32'h10);
      check("ws_instr", IF_ID_INSTR, 32'hC0DE_000C);
    end
    STALL = 1'b0; IMEM_RDY = 1'b1;
    step();
    check("ws_done_addr",  IMEM_ADDR, 32'h14);
    check("ws_done_ifpc",  IF_ID_PC, 32'h14);
    check("ws_done_instr", IF_ID_INSTR, 32'hC0DE_0010);

    repeat (3) step();
    check("pre_stall_addr", IMEM_ADDR, 32'h20);
    check("pre_stall_ifpc", IF_ID_PC, 32'h20);

    // Stall with data returning at 0x20: the word goes to the skid buffer.
    STALL = 1'b1; use_ovr = 1'b1; ovr_data = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      step();
      use_ovr = 1'b0;
      check("hold_req",   32'(IMEM_REQ), 0);
      check("hold_addr",  IMEM_ADDR, 32'h20);
      check("hold_ifpc",  IF_ID_PC, 32'h20);
      check("hold_instr", IF_ID_INSTR, 32'hC0DE_001C);
      check("hold_valid", 32'(IF_ID_VALID), 1);
    end
    STALL = 1'b0;
    step();
    check("skid_instr", IF_ID_INSTR, 32'hDEAD_BEEF);
    check("skid_ifpc",  IF_ID_PC, 32'h24);
    check("skid_addr",  IMEM_ADDR, 32'h24);
    check("skid_req",   32'(IMEM_REQ), 1);

    // Branch while RDY=1; the unaligned target gets its low bits cleared.
    BR_TAKEN = 1'b1; BR_TARGET = 32'h103;
    step();
    check("br_addr",  IMEM_ADDR, 32'h100);
    check("br_pcrf",  PC_RF, 32'h100);
    check("br_valid", 32'(IF_ID_VALID), 0);
    check("br_instr", IF_ID_INSTR, NOP);
    BR_TAKEN = 1'b0;
    step();
    check("br_next_addr",  IMEM_ADDR, 32'h104);
    check("br_next_ifpc",  IF_ID_PC, 32'h104);
    check("br_next_valid", 32'(IF_ID_VALID), 1);
    check("br_next_instr", IF_ID_INSTR, 32'hC0DE_0100);

    // Move to 0x40, then branch while a request is outstanding.
    BR_TAKEN = 1'b1; BR_TARGET = 32'h40;
    step();
    check("br40_addr", IMEM_ADDR, 32'h40);
    BR_TAKEN = 1'b0; IMEM_RDY = 1'b0;
    step();
    check("out_addr", IMEM_ADDR, 32'h40);
    BR_TAKEN = 1'b1; BR_TARGET = 32'h200;
    step();
    check("drain_addr",  IMEM_ADDR, 32'h40);
    check("drain_req",   32'(IMEM_REQ), 1);
    check("drain_valid", 32'(IF_ID_VALID), 0);
    check("drain_instr", IF_ID_INSTR, NOP);
    BR_TAKEN = 1'b0;
    step();
    check("drain2_addr", IMEM_ADDR, 32'h40);
    check("drain2_req",  32'(IMEM_REQ), 1);
    IMEM_RDY = 1'b1;
    step();
    check("redir_addr",  IMEM_ADDR, 32'h200);
    check("redir_valid", 32'(IF_ID_VALID), 0);
    check("redir_instr", IF_ID_INSTR, NOP);
    step();
    check("tgt_ifpc",  IF_ID_PC, 32'h204);
    check("tgt_valid", 32'(IF_ID_VALID), 1);
    check("tgt_instr", IF_ID_INSTR, 32'hC0DE_0200);
    check("tgt_addr",  IMEM_ADDR, 32'h204);

`ifdef FETCH_PERF_CNT_EN
    check("fetch_cnt", fetch_cnt, 32'd11);
    check("stall_cnt", stall_cnt, 32'd3);
`endif

    // PC wrap with RESET_PC = 32'hFFFF_FFFC.
    check("w_rst_addr", w_addr, 32'hFFFF_FFFC);
    check("w_rst_req",  32'(w_req), 0);
    rst2 = 1'b0;
    step();
    check("w_fetch_req",  32'(w_req), 1);
    check("w_fetch_addr", w_addr, 32'hFFFF_FFFC);
    step();
    check("w_ifpc",  w_ifpc, 32'h0);
    check("w_addr",  w_addr, 32'h0);
    check("w_pcrf",  w_pcrf, 32'h0);
    check("w_valid", 32'(w_valid), 1);
    check("w_instr", w_instr, 32'h1111_2222);
`ifdef FETCH_PERF_CNT_EN
    check("w_fetch_cnt", w_fetch_cnt, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
